cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

- Shares the single physical-memory port between the instruction cache (read-only) and the data cache (read/write).
- Sits between the two caches and the cacheline memory interface.
- Grants one cacheline transaction at a time with round-robin fairness.
- Holds the granted request stable on the memory side until the memory responds, then returns the response only to the winner.

## Interface

Parameters:
- ADDR_W, 32, byte address width
- LINE_W, 256, cacheline width in bits

Ports (the clock is single; reset is asynchronous, active-low):
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous active-low reset (0 = reset)
- i_read  in  1  instruction-cache line read request
- i_addr  in  ADDR_W  instruction-cache line address
- i_rdata  out  LINE_W  line returned to instruction cache
- i_resp  out  1  instruction-cache transaction done
- d_read  in  1  data-cache line read request
- d_write  in  1  data-cache line write request
- d_addr  in  ADDR_W  data-cache line address
- d_wdata  in  LINE_W  data-cache writeback line
- d_rdata  out  LINE_W  line returned to data cache
- d_resp  out  1  data-cache transaction done
- pmem_read  out  1  memory read strobe
- pmem_write  out  1  memory write strobe
- pmem_addr  out  ADDR_W  memory address
- pmem_wdata  out  LINE_W  memory write line
- pmem_rdata  in  LINE_W  memory read line
- pmem_resp  in  1  memory transaction done

## Operation

- The FSM has three states: IDLE, SERVE_I and SERVE_D.
- A 1-bit round-robin pointer `last` records the most recently granted port. It resets to I, so D has priority first.

IDLE:
- If only I requests (i_read), go to SERVE_I.
- If only D requests (d_read|d_write), go to SERVE_D.
- If both request, grant the port not equal to `last`.
- If neither requests, stay in IDLE.

On any grant:
- Latch the address into an internal register.
- Latch the op (read or write) into an internal register.
- For D writes, also latch d_wdata into an internal register.
- Update `last` to the granted port.

D op precedence:
- If d_read and d_write are both high, the op is a write.
- This is illegal stimulus; it is defined only for determinism.

SERVE_x (x = I or D):
- pmem_read or pmem_write equals the latched op. Exactly one is high.
- pmem_addr and pmem_wdata come from the latches.
- Requester inputs are ignored while in SERVE_x. A requester that drops or changes its request mid-transaction does not abort or alter it.
- When pmem_resp is 1, x_resp is 1 in that same cycle, and x_rdata = pmem_rdata (combinational).
- The next state is IDLE.

Response isolation:
- The non-granted port's resp is always 0.
- Its rdata is 0.

Idle outputs:
- pmem_resp while in IDLE is ignored; no resp is emitted.
- In IDLE, pmem_read = pmem_write = 0, pmem_addr = 0 and pmem_wdata = 0.

Requester contract:
- A requester holds its request until it sees resp.
- It deasserts its request in the cycle after resp.
- A request still high in the IDLE cycle after resp is treated as a new request.

## Timing

Reset (rst=0, asynchronous):
- State = IDLE and `last` = I.
- pmem_read = pmem_write = 0 and pmem_addr/pmem_wdata = 0.
- i_resp = d_resp = 0 and i_rdata/d_rdata = 0.
- These values take effect immediately, without waiting for a clock edge.
- Reset mid-transaction drops pmem_read/pmem_write at once and produces no resp.
- Deassertion of rst is synchronised by the integrator; the block samples requests from the first rising edge with rst=1.

Grant latency:
- A request seen in IDLE at edge N puts pmem_read/pmem_write high from edge N onward (registered state, 1 cycle after the request is presented).
- The pmem strobes are decoded from registered state and latches only. They are glitch-free with respect to requester inputs.

Response latency:
- x_resp asserts in the same cycle as pmem_resp (0 added cycles).
- The strobes drop at the next edge.

Back-to-back throughput:
- There is a minimum of one IDLE cycle between transactions.
- A transaction costs memory latency + 1 cycle.

Fairness:
- Under continuous contention, grants alternate I, D, I, D…
- No port waits longer than one foreign transaction.

Memory protocol:
- The memory sees stable pmem_addr, pmem_wdata and the strobe from grant until pmem_resp, inclusive.

## Test plan

- **Reset:** drive rst=0 mid SERVE_D write.
  - pmem_write goes to 0 immediately.
  - d_resp stays 0.
  - After release, the first dual request grants D (last=I).
- **Lone I read:** i_read=1, i_addr=0x0000_0040; memory answers after 5 cycles with 0xA5…A5.
  - pmem_read=1 and pmem_addr=0x40 from the next cycle.
  - i_resp=1 for exactly 1 cycle with i_rdata=0xA5…A5.
  - d_resp stays 0 throughout.
- **Lone D write:** d_write=1, d_addr=0x100, d_wdata=0x1234…; change d_addr/d_wdata to garbage after grant.
  - pmem_addr stays 0x100 and pmem_wdata stays 0x1234… until pmem_resp.
  - d_resp pulses once.
- **Contention:** i_read and d_read held high continuously, with requesters re-asserting after each resp.
  - Grant order is D, I, D, I.
  - There is exactly one IDLE cycle between consecutive strobes.
- **Spurious response and illegal op:**
  - pmem_resp=1 while in IDLE: no i_resp/d_resp.
  - d_read=d_write=1: pmem_write=1 and pmem_read=0.
- **Mid-transaction drop:** I granted; drop i_read two cycles later.
  - The transaction still completes.
  - i_resp pulses.
  - The next state is IDLE.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one cacheline memory port between the I-cache
// (read-only) and the D-cache (read/write). One transaction at a time,
// round-robin between the two requesters, with the winner's request
// latched and held on the memory side until pmem_resp.
module cache_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  // instruction cache
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  // data cache
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  // physical memory
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  // Round-robin pointer encoding: which port was granted most recently.
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;

  logic                i_req;
  logic                d_req;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // State register and transaction latches; async reset clears everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= PORT_I;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state and grant decision; latches load only on a grant from IDLE.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        // D wins when alone, or on contention when I was served last.
        if (d_req && (!i_req || (last_q == PORT_I))) begin
          state_d = SERVE_D;
          last_d  = PORT_D;
          addr_d  = d_addr;
          // Simultaneous read+write resolves to a write.
          wr_d    = d_write;
          if (d_write) begin
            wdata_d = d_wdata;
          end
        end else if (i_req) begin
          state_d = SERVE_I;
          last_d  = PORT_I;
          addr_d  = i_addr;
          wr_d    = 1'b0;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from registered state/latches; resp and rdata are
  // routed only to the port being served.
  always_comb begin
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_addr  = '0;
    pmem_wdata = '0;
    i_resp     = 1'b0;
    i_rdata    = '0;
    d_resp     = 1'b0;
    d_rdata    = '0;
    unique case (state_q)
      SERVE_I: begin
        pmem_read  = ~wr_q;
        pmem_write = wr_q;
        pmem_addr  = addr_q;
        pmem_wdata = wdata_q;
        i_resp     = pmem_resp;
        i_rdata    = pmem_rdata;
      end
      SERVE_D: begin
        pmem_read  = ~wr_q;
        pmem_write = wr_q;
        pmem_addr  = addr_q;
        pmem_wdata = wdata_q;
        d_resp     = pmem_resp;
        d_rdata    = pmem_rdata;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter.
module tb_cache_mem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;

  localparam logic [LINE_W-1:0] PAT_A5   = {32{8'hA5}};
  localparam logic [LINE_W-1:0] PAT_1234 = {8{32'h1234_5678}};
  localparam logic [LINE_W-1:0] PAT_BAD  = {8{32'hDEAD_BEEF}};

  logic              clk;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  int n_checks = 0;
  int n_fail   = 0;

  cache_mem_arbiter #(
    .ADDR_W(ADDR_W),
    .LINE_W(LINE_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_read    (i_read),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_resp    (i_resp),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_resp    (d_resp),
    .pmem_read (pmem_read),
    .pmem_write(pmem_write),
    .pmem_addr (pmem_addr),
    .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata),
    .pmem_resp (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                     input logic [LINE_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".rd"},   LINE_W'(pmem_read),  '0);
    chk({tag, ".wr"},   LINE_W'(pmem_write), '0);
    chk({tag, ".addr"}, LINE_W'(pmem_addr),  '0);
    chk({tag, ".wd"},   pmem_wdata,          '0);
  endtask

  initial begin
    rst        = 1'b0;
    i_read     = 1'b0;
    i_addr     = '0;
    d_read     = 1'b0;
    d_write    = 1'b0;
    d_addr     = '0;
    d_wdata    = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;

    // Reset values before any clock edge.
    #2;
    chk_idle("rst0");
    chk("rst0.iresp", LINE_W'(i_resp), '0);
    chk("rst0.dresp", LINE_W'(d_resp), '0);
    chk("rst0.irdata", i_rdata, '0);
    chk("rst0.drdata", d_rdata, '0);
    #10 rst = 1'b1;  // released at t=12, between edges

    // Lone I read, memory answers 5 cycles after grant.
    step();
    i_read = 1'b1;
    i_addr = 32'h0000_0040;
    step();
    chk("ird.rd",   LINE_W'(pmem_read),  LINE_W'(1));
    chk("ird.wr",   LINE_W'(pmem_write), '0);
    chk("ird.addr", LINE_W'(pmem_addr),  LINE_W'(32'h40));
    for (int k = 0; k < 4; k++) begin
      step();
      chk("ird.hold", LINE_W'(pmem_read), LINE_W'(1));
      chk("ird.nresp", LINE_W'(i_resp), '0);
      chk("ird.dresp", LINE_W'(d_resp), '0);
    end
    pmem_rdata = PAT_A5;
    pmem_resp  = 1'b1;
    #1;
    chk("ird.resp",  LINE_W'(i_resp), LINE_W'(1));
    chk("ird.rdata", i_rdata, PAT_A5);
    chk("ird.dresp2", LINE_W'(d_resp), '0);
    chk("ird.drdata", d_rdata, '0);
    step();
    pmem_resp = 1'b0;
    i_read    = 1'b0;
    chk("ird.resp_end", LINE_W'(i_resp), '0);
    chk_idle("ird.idle");

    // Lone D write; requester inputs scrambled after the grant.
    d_write = 1'b1;
    d_addr  = 32'h0000_0100;
    d_wdata = PAT_1234;
    step();
    chk("dwr.wr",   LINE_W'(pmem_write), LINE_W'(1));
    chk("dwr.rd",   LINE_W'(pmem_read),  '0);
    d_addr  = 32'hFFFF_FFF0;
    d_wdata = PAT_BAD;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("dwr.addr", LINE_W'(pmem_addr), LINE_W'(32'h100));
      chk("dwr.wd",   pmem_wdata, PAT_1234);
    end
    pmem_resp = 1'b1;
    #1;
    chk("dwr.resp",  LINE_W'(d_resp), LINE_W'(1));
    chk("dwr.iresp", LINE_W'(i_resp), '0);
    chk("dwr.addr_last", LINE_W'(pmem_addr), LINE_W'(32'h100));
    step();
    pmem_resp = 1'b0;
    d_write   = 1'b0;
    chk("dwr.resp_end", LINE_W'(d_resp), '0);
    chk_idle("dwr.idle");

    // Reset in the middle of a D write.
    d_write = 1'b1;
    d_addr  = 32'h0000_0180;
    d_wdata = PAT_1234;
    step();
    chk("rsw.wr", LINE_W'(pmem_write), LINE_W'(1));
    #2;
    rst       = 1'b0;
    pmem_resp = 1'b1;
    #1;
    chk_idle("rsw.async");
    chk("rsw.dresp", LINE_W'(d_resp), '0);
    chk("rsw.drdata", d_rdata, '0);
    d_write   = 1'b0;
    pmem_resp = 1'b0;
    step();
    chk_idle("rsw.held");
    #3 rst = 1'b1;

    // Contention after reset: grants D, I, D, I with one IDLE cycle between.
    i_read = 1'b1;
    i_addr = 32'h0000_0200;
    d_read = 1'b1;
    d_addr = 32'h0000_0300;
    for (int k = 0; k < 4; k++) begin
      logic exp_d;
      exp_d = (k % 2 == 0);
      step();
      chk("cnt.rd",   LINE_W'(pmem_read), LINE_W'(1));
      chk("cnt.addr", LINE_W'(pmem_addr),
          LINE_W'(exp_d ? 32'h300 : 32'h200));
      step();
      pmem_rdata = LINE_W'(k + 1);
      pmem_resp  = 1'b1;
      #1;
      chk("cnt.dresp", LINE_W'(d_resp), LINE_W'(exp_d));
      chk("cnt.iresp", LINE_W'(i_resp), LINE_W'(!exp_d));
      chk("cnt.rdata", exp_d ? d_rdata : i_rdata, LINE_W'(k + 1));
      step();
      pmem_resp = 1'b0;
      chk("cnt.gap", LINE_W'(pmem_read), '0);
    end
    i_read = 1'b0;
    d_read = 1'b0;
    step();
    chk_idle("cnt.idle");

    // Spurious memory response while idle.
    pmem_resp  = 1'b1;
    pmem_rdata = PAT_BAD;
    #1;
    chk("spur.iresp", LINE_W'(i_resp), '0);
    chk("spur.dresp", LINE_W'(d_resp), '0);
    chk("spur.irdata", i_rdata, '0);
    step();
    chk_idle("spur.idle");
    pmem_resp = 1'b0;

    // Illegal d_read+d_write resolves to a write.
    d_read  = 1'b1;
    d_write = 1'b1;
    d_addr  = 32'h0000_0400;
    d_wdata = PAT_A5;
    step();
    chk("ill.wr", LINE_W'(pmem_write), LINE_W'(1));
    chk("ill.rd", LINE_W'(pmem_read),  '0);
    chk("ill.wd", pmem_wdata, PAT_A5);
    pmem_resp = 1'b1;
    #1;
    chk("ill.resp", LINE_W'(d_resp), LINE_W'(1));
    step();
    pmem_resp = 1'b0;
    d_read    = 1'b0;
    d_write   = 1'b0;
    chk_idle("ill.idle");

    // I granted, request dropped two cycles later; transaction completes.
    i_read = 1'b1;
    i_addr = 32'h0000_0080;
    step();
    chk("drop.rd", LINE_W'(pmem_read), LINE_W'(1));
    step();
    step();
    i_read = 1'b0;
    step();
    chk("drop.hold", LINE_W'(pmem_read), LINE_W'(1));
    chk("drop.addr", LINE_W'(pmem_addr), LINE_W'(32'h80));
    pmem_rdata = PAT_1234;
    pmem_resp  = 1'b1;
    #1;
    chk("drop.resp",  LINE_W'(i_resp), LINE_W'(1));
    chk("drop.rdata", i_rdata, PAT_1234);
    step();
    pmem_resp = 1'b0;
    chk("drop.resp_end", LINE_W'(i_resp), '0);
    chk_idle("drop.idle");
    step();
    chk_idle("drop.stay");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
